udp_framer: RTL and testbench

- Transmit-side counterpart of the UDP receive filter.
- Accepts a payload byte count plus per-frame addressing, and computes the IPv4 header checksum.
- Emits a complete Ethernet II / IPv4 / UDP frame (FCS excluded) on a 64-bit AXI-Stream master. Payload is pulled from a 64-bit AXI-Stream slave and byte-realigned behind the 42-byte header.
- Sits between the payload FIFO and the MAC TX stream.

---
 rtl/udp_framer.sv | 220 ++++++++++++++++++++++
 tb/tb_udp_framer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_framer.sv
// UDP/IPv4/Ethernet II transmit framer: builds the 42-byte header, computes the
// IPv4 checksum and realigns the 64-bit payload stream behind it (FCS excluded).
module udp_framer #(
    parameter int unsigned MAX_PAYLOAD = 1472,
    parameter logic [7:0]  TTL         = 8'd64,
    localparam int unsigned DATA_WIDTH = 64
) (
    input  logic                    clk_i,
    input  logic                    a_rst_n_i,
    input  logic                    start_i,
    input  logic [10:0]             payload_len_i,
    input  logic [47:0]             src_mac_i,
    input  logic [47:0]             dst_mac_i,
    input  logic [31:0]             src_ip_i,
    input  logic [31:0]             dst_ip_i,
    input  logic [15:0]             src_port_i,
    input  logic [15:0]             dst_port_i,
    output logic                    busy_o,
    output logic                    err_o,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata_i,
    input  logic                    s_axis_tvalid_i,
    input  logic                    s_axis_tlast_i,
    output logic                    s_axis_tready_o,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata_o,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep_o,
    output logic                    m_axis_tvalid_o,
    output logic                    m_axis_tlast_o,
    input  logic                    m_axis_tready_i
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CSUM    = 3'd1;
    localparam logic [2:0] S_HDR     = 3'd2;
    localparam logic [2:0] S_HDR_PAY = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;
    localparam logic [2:0] S_FLUSH   = 3'd5;
    localparam logic [2:0] S_PAD     = 3'd6;

    logic [2:0]   state;
    logic [10:0]  len_q;
    logic [47:0]  src_mac_q, dst_mac_q;
    logic [31:0]  src_ip_q, dst_ip_q;
    logic [15:0]  src_port_q, dst_port_q;
    logic [15:0]  ip_id, csum_q, residue;
    logic [7:0]   beat_idx, last_beat, in_cnt, in_beats, last_keep;

    logic [11:0]  acc_bytes, acc_fbytes, byte_limit;
    logic         len_ok;
    logic [15:0]  tot_len, udp_len, fold2, csum_calc;
    logic [19:0]  csum_sum;
    logic [16:0]  fold1;
    logic [319:0] net_hdr, hdr_lsb;
    logic [63:0]  hdr_beat, raw_beat, out_beat;
    logic         can_load, consume_st, load, load_last, last_hs, in_final;

    // Frame geometry is derived once at acceptance from the requested length.
    always_comb begin
        acc_bytes  = 12'd42 + {1'b0, payload_len_i};
        acc_fbytes = (acc_bytes < 12'd60) ? 12'd60 : acc_bytes;
        len_ok     = (payload_len_i != '0) && ({21'h0, payload_len_i} <= MAX_PAYLOAD);
    end

    always_comb begin
        tot_len   = 16'd28 + {5'h0, len_q};
        udp_len   = 16'd8 + {5'h0, len_q};
        csum_sum  = {4'h0, 16'h4500} + {4'h0, tot_len} + {4'h0, ip_id}
                  + {4'h0, 16'h4000} + {4'h0, TTL, 8'h11}
                  + {4'h0, src_ip_q[31:16]} + {4'h0, src_ip_q[15:0]}
                  + {4'h0, dst_ip_q[31:16]} + {4'h0, dst_ip_q[15:0]};
        fold1     = {1'b0, csum_sum[15:0]} + {13'h0, csum_sum[19:16]};
        fold2     = fold1[15:0] + {15'h0, fold1[16]};
        csum_calc = ~fold2;
    end

    // Header bytes 0..39 in network order, then byte-swapped so wire byte n sits at [8n+7:8n].
    always_comb begin
        net_hdr = {dst_mac_q, src_mac_q, 16'h0800, 8'h45, 8'h00, tot_len, ip_id,
                   16'h4000, TTL, 8'h11, csum_q, src_ip_q, dst_ip_q,
                   src_port_q, dst_port_q, udp_len};
        hdr_lsb = '0;
        for (int unsigned n = 0; n < 40; n++) begin
            hdr_lsb[8*n +: 8] = net_hdr[319-8*n -: 8];
        end
        case (beat_idx[2:0])
            3'd0:    hdr_beat = hdr_lsb[63:0];
            3'd1:    hdr_beat = hdr_lsb[127:64];
            3'd2:    hdr_beat = hdr_lsb[191:128];
            3'd3:    hdr_beat = hdr_lsb[255:192];
            3'd4:    hdr_beat = hdr_lsb[319:256];
            default: hdr_beat = '0;
        endcase
    end

    always_comb begin
        case (state)
            S_HDR:     raw_beat = hdr_beat;
            S_HDR_PAY: raw_beat = {s_axis_tdata_i[47:0], 16'h0000};
            S_PAYLOAD: raw_beat = {s_axis_tdata_i[47:0], residue};
            S_FLUSH:   raw_beat = {48'h0, residue};
            default:   raw_beat = '0;
        endcase
        // Anything at or beyond frame byte 42+len is padding or dropped input and reads as zero.
        byte_limit = 12'd42 + {1'b0, len_q};
        out_beat   = '0;
        for (int unsigned l = 0; l < 8; l++) begin
            if (({1'b0, beat_idx, 3'b000} + 12'(l)) < byte_limit) begin
                out_beat[8*l +: 8] = raw_beat[8*l +: 8];
            end
        end
    end

    // No new beat may load once the last beat sits in the output register.
    always_comb begin
        can_load   = !m_axis_tvalid_o || (m_axis_tready_i && !m_axis_tlast_o);
        consume_st = (state == S_HDR_PAY) || (state == S_PAYLOAD);
        load       = can_load && ((state == S_HDR) || (state == S_FLUSH) || (state == S_PAD)
                                  || (consume_st && s_axis_tvalid_i));
        load_last  = (beat_idx == last_beat);
        last_hs    = m_axis_tvalid_o && m_axis_tready_i && m_axis_tlast_o;
        in_final   = ((in_cnt + 8'd1) == in_beats);
    end

    assign s_axis_tready_o = consume_st && can_load;

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state           <= S_IDLE;
            len_q           <= '0;
            src_mac_q       <= '0;
            dst_mac_q       <= '0;
            src_ip_q        <= '0;
            dst_ip_q        <= '0;
            src_port_q      <= '0;
            dst_port_q      <= '0;
            ip_id           <= '0;
            csum_q          <= '0;
            residue         <= '0;
            beat_idx        <= '0;
            last_beat       <= '0;
            in_cnt          <= '0;
            in_beats        <= '0;
            last_keep       <= '0;
            busy_o          <= 1'b0;
            err_o           <= 1'b0;
            m_axis_tdata_o  <= '0;
            m_axis_tkeep_o  <= '0;
            m_axis_tvalid_o <= 1'b0;
            m_axis_tlast_o  <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (last_hs) begin
                m_axis_tvalid_o <= 1'b0;
                m_axis_tlast_o  <= 1'b0;
                busy_o          <= 1'b0;
                ip_id           <= ip_id + 16'd1;
                state           <= S_IDLE;
            end else if (m_axis_tvalid_o && m_axis_tready_i) begin
                m_axis_tvalid_o <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        if (len_ok) begin
                            len_q      <= payload_len_i;
                            src_mac_q  <= src_mac_i;
                            dst_mac_q  <= dst_mac_i;
                            src_ip_q   <= src_ip_i;
                            dst_ip_q   <= dst_ip_i;
                            src_port_q <= src_port_i;
                            dst_port_q <= dst_port_i;
                            last_beat  <= 8'((acc_fbytes + 12'd7) >> 3) - 8'd1;
                            in_beats   <= 8'(({1'b0, payload_len_i} + 12'd7) >> 3);
                            last_keep  <= (acc_fbytes[2:0] == 3'd0) ? 8'hFF
                                        : 8'((9'h001 << acc_fbytes[2:0]) - 9'h001);
                            busy_o     <= 1'b1;
                            state      <= S_CSUM;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                S_CSUM: begin
                    csum_q   <= csum_calc;
                    beat_idx <= '0;
                    in_cnt   <= '0;
                    residue  <= '0;
                    state    <= S_HDR;
                end
                default: begin
                    if (load) begin
                        m_axis_tdata_o  <= out_beat;
                        m_axis_tvalid_o <= 1'b1;
                        m_axis_tlast_o  <= load_last;
                        m_axis_tkeep_o  <= load_last ? last_keep : 8'hFF;
                        beat_idx        <= beat_idx + 8'd1;
                        case (state)
                            S_HDR: begin
                                if (beat_idx == 8'd4) state <= S_HDR_PAY;
                            end
                            S_HDR_PAY, S_PAYLOAD: begin
                                residue <= s_axis_tdata_i[63:48];
                                in_cnt  <= in_cnt + 8'd1;
                                // tlast must coincide exactly with the final expected input beat.
                                if (s_axis_tlast_i != in_final) err_o <= 1'b1;
                                state <= (!s_axis_tlast_i && !in_final) ? S_PAYLOAD : S_FLUSH;
                            end
                            S_FLUSH: begin
                                residue <= '0;
                                state   <= S_PAD;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_framer.sv
// Self-checking bench for udp_framer: randomized payload/handshakes scored against
// a byte-level frame model, plus literal checks of known frame fields.
module tb_udp_framer;

    typedef struct packed { logic [63:0] data; logic last; } in_beat_t;
    typedef struct packed { logic [63:0] data; logic [7:0] keep; logic last; } out_beat_t;

    logic        clk = 1'b0;
    logic        a_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] plen = '0;
    logic [47:0] smac = '0, dmac = '0;
    logic [31:0] sip = '0, dip = '0;
    logic [15:0] sport = '0, dport = '0;
    logic        busy, err;
    logic [63:0] s_tdata = '0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tlast;
    logic        m_tready = 1'b0;

    always #5 clk = ~clk;

    udp_framer #(.MAX_PAYLOAD(1472), .TTL(8'd64)) dut (
        .clk_i(clk), .a_rst_n_i(a_rst_n), .start_i(start), .payload_len_i(plen),
        .src_mac_i(smac), .dst_mac_i(dmac), .src_ip_i(sip), .dst_ip_i(dip),
        .src_port_i(sport), .dst_port_i(dport), .busy_o(busy), .err_o(err),
        .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tlast_i(s_tlast),
        .s_axis_tready_o(s_tready), .m_axis_tdata_o(m_tdata), .m_axis_tkeep_o(m_tkeep),
        .m_axis_tvalid_o(m_tvalid), .m_axis_tlast_o(m_tlast), .m_axis_tready_i(m_tready)
    );

    in_beat_t    src_q[$];
    out_beat_t   exp_q[$];
    out_beat_t   rx_q[$];
    out_beat_t   mon_e;
    int unsigned checks = 0, passed = 0;
    int unsigned err_cnt = 0, busy_cnt = 0, consumed = 0;
    int unsigned rdy_pct = 100, vld_pct = 100;
    logic        in_hs = 1'b0;
    logic [15:0] model_id = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] kmask(input logic [7:0] k);
        logic [63:0] m;
        for (int l = 0; l < 8; l++) m[8*l +: 8] = {8{k[l]}};
        return m;
    endfunction

    function automatic out_beat_t rxb(input int i);
        if (i < int'(rx_q.size())) return rx_q[i];
        return '0;
    endfunction

    function automatic logic [15:0] ip_csum(input int unsigned len, input logic [15:0] id,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        s = 32'h4500 + (28 + len) + id + 32'h4000 + 32'h4011
          + a[31:16] + a[15:0] + b[31:16] + b[15:0];
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return 16'(~s);
    endfunction

    // Monitor: samples mid-cycle, scores every output handshake against the model queue.
    always @(negedge clk) begin
        in_hs = s_tvalid && s_tready;
        if (in_hs) consumed++;
        if (err) err_cnt++;
        if (busy) busy_cnt++;
        if (m_tvalid && m_tready) begin
            rx_q.push_back('{m_tdata, m_tkeep, m_tlast});
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_beat: got %h expected no beat", m_tdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_data", m_tdata & kmask(mon_e.keep), mon_e.data & kmask(mon_e.keep));
                chk("beat_keep", m_tkeep, mon_e.keep);
                chk("beat_last", m_tlast, mon_e.last);
            end
        end
    end

    // Stream drivers: inputs change just after the rising edge.
    initial forever begin
        @(posedge clk); #1;
        if (in_hs && src_q.size() > 0) void'(src_q.pop_front());
        if (src_q.size() > 0 && ((s_tvalid && !in_hs) || ($urandom_range(99) < vld_pct))) begin
            s_tvalid = 1'b1;
            s_tdata  = src_q[0].data;
            s_tlast  = src_q[0].last;
        end else begin
            s_tvalid = 1'b0;
            s_tdata  = {$urandom, $urandom};
            s_tlast  = 1'($urandom_range(1));
        end
        m_tready = ($urandom_range(99) < rdy_pct);
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_frame(input int unsigned len, input int early, input bit drop_last,
                             input bit poke, input int abort_beat,
                             input logic [31:0] a_ip, input logic [31:0] b_ip);
        logic [7:0]   bytes[$];
        logic [63:0]  pay[$];
        logic [335:0] hdr;
        logic [47:0]  sm, dm;
        logic [15:0]  sp, dp;
        int unsigned  nbeats, supply, nb, cnt;
        logic [63:0]  d;
        nbeats = (len + 7) / 8;
        supply = (early >= 0) ? unsigned'(early) + 1 : nbeats;
        for (int unsigned k = 0; k < supply; k++) begin
            d = {$urandom, $urandom};
            pay.push_back(d);
            src_q.push_back('{d, !drop_last && (k == supply - 1)});
        end
        sm = {$urandom, $urandom}; dm = {$urandom, $urandom};
        sp = 16'($urandom); dp = 16'($urandom);
        hdr = {dm, sm, 16'h0800, 8'h45, 8'h00, 16'(28 + len), model_id, 16'h4000, 8'd64, 8'h11,
               ip_csum(len, model_id, a_ip, b_ip), a_ip, b_ip, sp, dp, 16'(8 + len), 16'h0000};
        for (int i = 0; i < 42; i++) bytes.push_back(hdr[335-8*i -: 8]);
        for (int unsigned i = 0; i < len; i++)
            bytes.push_back((i / 8 < supply) ? pay[i/8][8*(i%8) +: 8] : 8'h00);
        while (bytes.size() < 60) bytes.push_back(8'h00);
        nb = (bytes.size() + 7) / 8;
        for (int unsigned b = 0; b < nb; b++) begin
            d = '0; cnt = 0;
            for (int unsigned l = 0; l < 8; l++)
                if (8*b + l < bytes.size()) begin d[8*l +: 8] = bytes[8*b + l]; cnt++; end
            exp_q.push_back('{d, (cnt == 8) ? 8'hFF : 8'((1 << cnt) - 1), b == nb - 1});
        end
        err_cnt = 0; consumed = 0; rx_q.delete();

        @(posedge clk); #1;
        start = 1'b1; plen = 11'(len); smac = sm; dmac = dm; sip = a_ip; dip = b_ip;
        sport = sp; dport = dp;
        @(posedge clk); #1;
        start = 1'b0; plen = 11'($urandom); smac = {$urandom, $urandom}; dmac = {$urandom, $urandom};
        sip = $urandom; dip = $urandom; sport = 16'($urandom); dport = 16'($urandom);

        if (abort_beat >= 0) begin
            for (int c = 0; c < 2000; c++) begin
                if (int'(rx_q.size()) >= abort_beat) break;
                @(negedge clk);
            end
            chk("abort_reached", 64'(int'(rx_q.size()) >= abort_beat), 64'd1);
            @(posedge clk); #2;
            a_rst_n = 1'b0;
            #1;
            chk("rst_tvalid", m_tvalid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            src_q.delete(); exp_q.delete(); model_id = '0;
            repeat (2) @(posedge clk);
            #1 a_rst_n = 1'b1;
            return;
        end

        if (poke) begin
            repeat (10) @(posedge clk);
            #1 start = 1'b1; plen = 11'd8;
            @(posedge clk); #1 start = 1'b0;
        end

        for (int c = 0; c < 20000; c++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(negedge clk);
        end
        chk("frame_done", 64'(exp_q.size() == 0 && !busy), 64'd1);
        chk("in_consumed", 64'(consumed), 64'(supply));
        chk("err_pulses", 64'(err_cnt), 64'((early >= 0 || drop_last) ? 1 : 0));
        chk("rx_beats", 64'(rx_q.size()), 64'(nb));
        model_id++;
        if (poke) begin
            busy_cnt = 0;
            wait_cycles(6);
            chk("poke_ignored", 64'(busy_cnt), 64'd0);
        end
    endtask

    task automatic reject(input int unsigned len);
        err_cnt = 0; busy_cnt = 0;
        @(posedge clk); #1 start = 1'b1; plen = 11'(len);
        @(posedge clk); #1 start = 1'b0;
        wait_cycles(4);
        chk("reject_err", 64'(err_cnt), 64'd1);
        chk("reject_busy", 64'(busy_cnt), 64'd0);
    endtask

    initial begin
        a_rst_n = 1'b0;
        wait_cycles(3);
        chk("reset_outputs", {m_tdata, m_tkeep, m_tvalid, m_tlast, busy, err, s_tready}, '0);
        @(posedge clk); #1 a_rst_n = 1'b1;
        wait_cycles(2);

        chk("model_csum", 64'(ip_csum(8, 16'h0000, 32'hC0A8010A, 32'hC0A80114)), 64'hB75A);
        run_frame(8, -1, 0, 0, -1, 32'hC0A8010A, 32'hC0A80114);
        chk("csum_lanes", rxb(3).data[15:0], 16'h5AB7);
        chk("ethertype", rxb(1).data[47:32], 16'h0008);
        chk("len8_beats", 64'(rx_q.size()), 64'd8);
        chk("len8_keep", rxb(7).keep, 8'h0F);
        chk("len8_pad6", rxb(6).data[63:16], 48'h0);
        chk("len8_pad7", rxb(7).data[31:0], 32'h0);

        run_frame(16, -1, 0, 0, -1, $urandom, $urandom);
        chk("id_second", rxb(2).data[31:16], 16'h0100);

        rdy_pct = 60; vld_pct = 70;
        run_frame(7, -1, 0, 0, -1, $urandom, $urandom);
        chk("len7_keep", rxb(7).keep, 8'h0F);
        chk("len7_pad", rxb(6).data[63:8], 56'h0);
        run_frame(15, -1, 0, 0, -1, $urandom, $urandom);
        chk("len15_beats", 64'(rx_q.size()), 64'd8);
        chk("len15_keep", rxb(7).keep, 8'h0F);
        run_frame(19, -1, 0, 0, -1, $urandom, $urandom);
        chk("len19_beats", 64'(rx_q.size()), 64'd8);
        chk("len19_keep", rxb(7).keep, 8'h1F);

        run_frame(1472, -1, 0, 0, -1, $urandom, $urandom);
        chk("max_beats", 64'(rx_q.size()), 64'd190);
        chk("max_keep", rxb(189).keep, 8'h03);

        run_frame(24, 0, 0, 0, -1, $urandom, $urandom);
        chk("early_beats", 64'(rx_q.size()), 64'd9);
        chk("early_zero6", rxb(6).data[63:16], 48'h0);
        chk("early_zero7", rxb(7).data, 64'h0);
        chk("early_zero8", rxb(8).data[15:0], 16'h0);
        chk("early_keep", rxb(8).keep, 8'h03);

        run_frame(20, -1, 1, 0, -1, $urandom, $urandom);

        reject(0);
        reject(1473);

        run_frame(200, -1, 0, 1, -1, $urandom, $urandom);

        for (int i = 0; i < 6; i++) begin
            rdy_pct = $urandom_range(40, 100); vld_pct = $urandom_range(40, 100);
            run_frame($urandom_range(1, 300), -1, 0, 0, -1, $urandom, $urandom);
        end

        rdy_pct = 100; vld_pct = 100;
        run_frame(64, -1, 0, 0, 3, $urandom, $urandom);
        wait_cycles(2);
        run_frame(32, -1, 0, 0, -1, $urandom, $urandom);
        chk("id_after_reset", rxb(2).data[31:16], 16'h0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
